// File: rtl/result_reader_pkg.sv
// Shared definitions for the result reader and its neighbours on the memory bus.
// Memory command encodings are common to every bus initiator and the Memory.
// The reader FSM state type is a 3-bit enum.
package result_reader_pkg;

    // Memory command encodings shared by Memory, Median_Filter, Coordinator and reader
    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } reader_state_t;

endpackage

// File: rtl/result_reader_pixel_addr_counter.sv
// Raster position tracker for the filtered image.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   load                restart at (0,0), address OUT_BASE
//   advance             step to the next pixel in raster order
//   row, col, addr      current pixel position and its memory address
//   last                current pixel is the final one of the image
module result_reader_pixel_addr_counter #(
    parameter int BUS_WIDTH  = 8,
    parameter int OUT_BASE   = 81,
    parameter int OUT_WIDTH  = 7,
    parameter int OUT_HEIGHT = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 advance,
    output logic [BUS_WIDTH-1:0] row,
    output logic [BUS_WIDTH-1:0] col,
    output logic [BUS_WIDTH-1:0] addr,
    output logic                 last
);

    localparam logic [BUS_WIDTH-1:0] LAST_COL = BUS_WIDTH'(OUT_WIDTH - 1);
    localparam logic [BUS_WIDTH-1:0] LAST_ROW = BUS_WIDTH'(OUT_HEIGHT - 1);
    localparam logic [BUS_WIDTH-1:0] BASE     = BUS_WIDTH'(OUT_BASE);

    // The address steps by one every pixel because the image is stored
    // contiguously; row/col only serve as tags for the downstream consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            col  <= '0;
            addr <= '0;
        end else if (load) begin
            row  <= '0;
            col  <= '0;
            addr <= BASE;
        end else if (advance) begin
            addr <= addr + 1'b1;
            if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (row == LAST_ROW) && (col == LAST_COL);

endmodule

// File: rtl/result_reader.sv
// Streams the filtered image out of the shared Memory in raster order.
// One read per pixel is issued once the Coordinator grants the bus; each
// returned word leaves on a valid/ready interface tagged with row/col/last.
// Ports:
//   Reader_CLK, Reader_RST_N     clock, asynchronous active-low reset
//   Reader_STRT                  start pulse (honoured only when idle)
//   Reader_GNT                   bus granted to this block
//   Reader_MEMADDR/MEMRW         memory address and command (read only)
//   Reader_MEMODR/DRDY           memory read data and data-ready
//   Reader_PIX/ROW/COL/LAST      pixel and its tags, qualified by VALID
//   Reader_VALID/READY           output handshake
//   Reader_BUSY/DNE/ERR          status: busy, completion pulse, sticky timeout
module result_reader
    import result_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 8,
    parameter int OUT_BASE   = 81,
    parameter int OUT_WIDTH  = 7,
    parameter int OUT_HEIGHT = 7,
    parameter int TIMEOUT    = 15
) (
    input  logic                  Reader_CLK,
    input  logic                  Reader_RST_N,
    input  logic                  Reader_STRT,
    input  logic                  Reader_GNT,
    output logic [BUS_WIDTH-1:0]  Reader_MEMADDR,
    output logic [1:0]            Reader_MEMRW,
    input  logic [DATA_WIDTH-1:0] Reader_MEMODR,
    input  logic                  Reader_DRDY,
    output logic [DATA_WIDTH-1:0] Reader_PIX,
    output logic [BUS_WIDTH-1:0]  Reader_ROW,
    output logic [BUS_WIDTH-1:0]  Reader_COL,
    output logic                  Reader_VALID,
    input  logic                  Reader_READY,
    output logic                  Reader_LAST,
    output logic                  Reader_BUSY,
    output logic                  Reader_DNE,
    output logic                  Reader_ERR
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT - 1);

    // The image must fit below the top of the address space so the address
    // counter never wraps.
    if (OUT_BASE + OUT_WIDTH * OUT_HEIGHT > (1 << BUS_WIDTH)) begin : g_addr_range_check
        $fatal(1, "result_reader: image does not fit in the address space");
    end

    reader_state_t state, next_state;

    logic                  load, advance, issue, capture, timeout;
    logic [BUS_WIDTH-1:0]  cnt_row, cnt_col, cnt_addr;
    logic                  cnt_last;
    logic [TW-1:0]         wait_cnt;
    logic [BUS_WIDTH-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] pix_q;
    logic [BUS_WIDTH-1:0]  row_q, col_q;
    logic                  last_q;
    logic                  err_q;

    result_reader_pixel_addr_counter #(
        .BUS_WIDTH  (BUS_WIDTH),
        .OUT_BASE   (OUT_BASE),
        .OUT_WIDTH  (OUT_WIDTH),
        .OUT_HEIGHT (OUT_HEIGHT)
    ) u_pixel_addr_counter (
        .clk     (Reader_CLK),
        .rst_n   (Reader_RST_N),
        .load    (load),
        .advance (advance),
        .row     (cnt_row),
        .col     (cnt_col),
        .addr    (cnt_addr),
        .last    (cnt_last)
    );

    always_ff @(posedge Reader_CLK or negedge Reader_RST_N) begin
        if (!Reader_RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A read, once issued, always runs to DRDY or timeout: GNT is only looked
    // at in REQ. The OUT exit uses the captured LAST rather than the counter so
    // the decision matches exactly what was presented downstream.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Reader_STRT) begin
                    load       = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (Reader_GNT) begin
                    issue      = 1'b1;
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Reader_DRDY) begin
                    capture    = 1'b1;
                    next_state = ST_OUT;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    timeout    = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_OUT: begin
                if (Reader_READY) begin
                    if (last_q) begin
                        next_state = ST_DONE;
                    end else begin
                        advance    = 1'b1;
                        next_state = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Address is latched when the read is issued so it stays stable for the
    // whole WAIT; the wait counter restarts with every read.
    always_ff @(posedge Reader_CLK or negedge Reader_RST_N) begin
        if (!Reader_RST_N) begin
            mem_addr <= '0;
            wait_cnt <= '0;
        end else if (issue) begin
            mem_addr <= cnt_addr;
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Pixel and tags are captured together with DRDY and then held for the
    // whole handshake.
    always_ff @(posedge Reader_CLK or negedge Reader_RST_N) begin
        if (!Reader_RST_N) begin
            pix_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            last_q <= 1'b0;
        end else if (capture) begin
            pix_q  <= Reader_MEMODR;
            row_q  <= cnt_row;
            col_q  <= cnt_col;
            last_q <= cnt_last;
        end
    end

    // Timeout flag survives until the next accepted start.
    always_ff @(posedge Reader_CLK or negedge Reader_RST_N) begin
        if (!Reader_RST_N) begin
            err_q <= 1'b0;
        end else if (load) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign Reader_MEMADDR = mem_addr;
    assign Reader_MEMRW   = (state == ST_WAIT) ? MEM_READ : MEM_IDLE;
    assign Reader_PIX     = pix_q;
    assign Reader_ROW     = row_q;
    assign Reader_COL     = col_q;
    assign Reader_LAST    = (state == ST_OUT) && last_q;
    assign Reader_VALID   = (state == ST_OUT);
    assign Reader_BUSY    = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_OUT);
    assign Reader_DNE     = (state == ST_DONE);
    assign Reader_ERR     = err_q;

endmodule
